// File: rtl/cmos_rgb565_capture_if.sv
// Camera-side and pixel-side signal bundle for cmos_rgb565_capture.
// master: the capture block (takes sensor pins, drives the pixel stream).
// slave : the sensor model / frame writer on the other side.
interface cmos_rgb565_capture_if;
    logic        cmos_vsync;
    logic        cmos_href;
    logic [7:0]  cmos_d;
    logic        pix_vld;
    logic [23:0] pix_data;
    logic        frame_start;
    logic        line_end;
    logic        frame_end;
    logic        frame_err;
    logic [7:0]  frame_cnt;

    modport master (
        input  cmos_vsync, cmos_href, cmos_d,
        output pix_vld, pix_data, frame_start, line_end, frame_end, frame_err, frame_cnt
    );

    modport slave (
        output cmos_vsync, cmos_href, cmos_d,
        input  pix_vld, pix_data, frame_start, line_end, frame_end, frame_err, frame_cnt
    );
endinterface

// File: rtl/cmos_rgb565_capture.sv
// OV5640 parallel-port capture: skips the first FRAME_SKIP frames, pairs
// bytes into RGB565 pixels, emits frame/line markers and flags frames whose
// geometry does not match H_ACTIVE x V_ACTIVE.
// Optional macro CAPTURE_RGB888_EN: widen pix_data to RGB888 by MSB
// replication instead of zero-padding the RGB565 word.
module cmos_rgb565_capture #(
    parameter int unsigned FRAME_SKIP = 10,
    parameter int unsigned H_ACTIVE   = 1024,
    parameter int unsigned V_ACTIVE   = 768,
    parameter bit          VSYNC_POL  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  capture_en,
    cmos_rgb565_capture_if.master cam
);

    localparam int SKW    = (FRAME_SKIP > 0) ? $clog2(FRAME_SKIP + 1) : 1;
    localparam bit VS_INV = ~VSYNC_POL;

    typedef enum logic [1:0] {
        SKIP   = 2'd0,
        IDLE   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [SKW-1:0] skip_cnt, skip_cnt_nxt;

    logic        vs_r, hr_r, hr_q, vs_q;
    logic [7:0]  d_r;
    logic        vs_i, lead, rise, fall;

    logic        phase, drop, first_pend;
    logic [7:0]  hi_byte;
    logic [15:0] rgb;
    logic [23:0] pix_fmt;
    logic [11:0] pix_cnt, line_cnt, line_cnt_fin;
    logic        line_err;
    logic        arm, close, glitch, pair_go, line_ok, line_bad;

    // vsync normalised to active-high; edges judged between registered samples
    assign vs_i = vs_r ^ VS_INV;
    assign lead = vs_i & ~vs_q;
    assign rise = hr_r & ~hr_q;
    assign fall = ~hr_r & hr_q;

    assign rgb = {hi_byte, d_r};
`ifdef CAPTURE_RGB888_EN
    assign pix_fmt = {rgb[15:11], rgb[15:13], rgb[10:5], rgb[10:9], rgb[4:0], rgb[4:2]};
`else
    assign pix_fmt = {8'h00, rgb};
`endif

    // Sensor pins are registered once before any decision is made
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_r <= VS_INV;
            vs_q <= 1'b0;
            hr_r <= 1'b0;
            hr_q <= 1'b0;
            d_r  <= 8'h00;
        end else begin
            vs_r <= cam.cmos_vsync;
            vs_q <= vs_i;
            hr_r <= cam.cmos_href;
            hr_q <= hr_r;
            d_r  <= cam.cmos_d;
        end
    end

    // State register and skip counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SKIP;
            skip_cnt <= '0;
        end else begin
            state    <= state_nxt;
            skip_cnt <= skip_cnt_nxt;
        end
    end

    // Frame-boundary decisions plus per-cycle pairing/check qualifiers
    always_comb begin
        state_nxt    = state;
        skip_cnt_nxt = skip_cnt;
        case (state)
            SKIP: begin
                if (lead) begin
                    if (skip_cnt == SKW'(FRAME_SKIP))
                        state_nxt = capture_en ? ACTIVE : IDLE;
                    else
                        skip_cnt_nxt = skip_cnt + SKW'(1);
                end
            end
            IDLE:    if (lead && capture_en)  state_nxt = ACTIVE;
            ACTIVE:  if (lead && !capture_en) state_nxt = IDLE;
            default: state_nxt = SKIP;
        endcase
        arm          = lead && (state_nxt == ACTIVE);
        close        = lead && (state == ACTIVE);
        // vsync edge while a line is running: that line is thrown away
        glitch       = lead && hr_r;
        pair_go      = (state == ACTIVE) && hr_r && phase && !drop && !glitch;
        line_ok      = (state == ACTIVE) && fall && !drop;
        line_bad     = line_ok && ((pix_cnt != 12'(H_ACTIVE)) || phase);
        line_cnt_fin = (line_ok && line_cnt != 12'hFFF) ? line_cnt + 12'd1 : line_cnt;
    end

    // Byte pairing and pixel strobe; frame_start rides on the first pixel after arming
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase           <= 1'b0;
            drop            <= 1'b0;
            first_pend      <= 1'b0;
            hi_byte         <= 8'h00;
            cam.pix_vld     <= 1'b0;
            cam.pix_data    <= 24'h0;
            cam.frame_start <= 1'b0;
        end else begin
            phase <= hr_r ? ~phase : 1'b0;
            if (hr_r && !phase)
                hi_byte <= d_r;
            if (!hr_r)
                drop <= 1'b0;
            else if (glitch)
                drop <= 1'b1;
            if (lead)
                first_pend <= arm;
            else if (pair_go)
                first_pend <= 1'b0;
            cam.pix_vld     <= pair_go;
            cam.frame_start <= pair_go && first_pend;
            if (pair_go)
                cam.pix_data <= pix_fmt;
        end
    end

    // Geometry counters, per-line checks and frame close reporting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt       <= 12'h0;
            line_cnt      <= 12'h0;
            line_err      <= 1'b0;
            cam.line_end  <= 1'b0;
            cam.frame_end <= 1'b0;
            cam.frame_err <= 1'b0;
            cam.frame_cnt <= 8'h00;
        end else begin
            if (rise)
                pix_cnt <= 12'h0;
            else if (pair_go && pix_cnt != 12'hFFF)
                pix_cnt <= pix_cnt + 12'd1;
            if (lead) begin
                line_cnt <= 12'h0;
                line_err <= 1'b0;
            end else begin
                line_cnt <= line_cnt_fin;
                if (line_bad)
                    line_err <= 1'b1;
            end
            cam.line_end  <= line_ok;
            cam.frame_end <= close;
            if (close) begin
                cam.frame_err <= line_err || line_bad || (line_cnt_fin != 12'(V_ACTIVE)) || glitch;
                cam.frame_cnt <= cam.frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_cmos_rgb565_capture.sv
// Randomised-byte bench for cmos_rgb565_capture. Two instances run in
// parallel (active-high and active-low vsync) against one frame-level model
// that predicts, per cycle, every pixel, marker pulse and counter value.
`timescale 1ns/1ps
module tb_cmos_rgb565_capture;
    localparam int FS = 2, H = 4, V = 2;
`ifdef CAPTURE_RGB888_EN
    localparam logic [23:0] EXP_F81F = 24'hFF00FF;
`else
    localparam logic [23:0] EXP_F81F = 24'h00F81F;
`endif

    logic clk = 1'b0, rst_n = 1'b0, cap = 1'b1;
    logic vs_pin = 1'b0, hr_pin = 1'b0;
    logic [7:0] d_pin = 8'h00;
    int cyc = 0, tests = 0, fails = 0;

    always #5 clk = ~clk;

    cmos_rgb565_capture_if ifh ();
    cmos_rgb565_capture_if ifl ();
    assign ifh.cmos_vsync = vs_pin;
    assign ifh.cmos_href  = hr_pin;
    assign ifh.cmos_d     = d_pin;
    assign ifl.cmos_vsync = ~vs_pin;
    assign ifl.cmos_href  = hr_pin;
    assign ifl.cmos_d     = d_pin;

    cmos_rgb565_capture #(.FRAME_SKIP(FS), .H_ACTIVE(H), .V_ACTIVE(V), .VSYNC_POL(1'b1))
        dut_h (.clk(clk), .rst_n(rst_n), .capture_en(cap), .cam(ifh));
    cmos_rgb565_capture #(.FRAME_SKIP(FS), .H_ACTIVE(H), .V_ACTIVE(V), .VSYNC_POL(1'b0))
        dut_l (.clk(clk), .rst_n(rst_n), .capture_en(cap), .cam(ifl));

    // expected output timeline, keyed by cycle number
    logic [23:0] exp_pix [int];
    bit          exp_fs  [int];
    bit          exp_le  [int];
    bit          exp_fe  [int];
    bit          exp_fer [int];
    logic [7:0]  exp_fc  [int];
    logic [7:0]  cur_fc = 8'h00;
    bit          cur_fer = 1'b0;

    // frame-level model state
    bit         m_act = 0, m_first = 0, m_drop = 0, m_lerr = 0, pvs = 0, phr = 0;
    int         m_seen = 0, m_nb = 0, m_lines = 0;
    logic [7:0] m_hi = 8'h00, m_fc = 8'h00;

    int          mon_cnt = 0;
    logic [23:0] fs_pix = 24'h0;

    function automatic logic [23:0] px(input logic [7:0] hi, input logic [7:0] lo);
        logic [15:0] w;
        logic [4:0]  r, b;
        logic [5:0]  g;
        w = {hi, lo};
        r = w[15:11];
        g = w[10:5];
        b = w[4:0];
`ifdef CAPTURE_RGB888_EN
        return {r, r[4:2], g, g[5:4], b, b[4:2]};
`else
        return {8'h00, w};
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic cmp(input string nm, input logic vld, input logic [23:0] dat, input logic fs,
                       input logic le, input logic fe, input logic fer, input logic [7:0] fc);
        chk({nm, ".pix_vld"}, 32'(vld), 32'(exp_pix.exists(cyc)));
        if (vld && exp_pix.exists(cyc))
            chk({nm, ".pix_data"}, 32'(dat), 32'(exp_pix[cyc]));
        chk({nm, ".frame_start"}, 32'(fs), 32'(exp_fs.exists(cyc)));
        chk({nm, ".line_end"}, 32'(le), 32'(exp_le.exists(cyc)));
        chk({nm, ".frame_end"}, 32'(fe), 32'(exp_fe.exists(cyc)));
        chk({nm, ".frame_err"}, 32'(fer), 32'(cur_fer));
        chk({nm, ".frame_cnt"}, 32'(fc), 32'(cur_fc));
    endtask

    task automatic zcheck(input string nm, input logic vld, input logic [23:0] dat, input logic fs,
                          input logic le, input logic fe, input logic fer, input logic [7:0] fc);
        chk({nm, ".rst_outputs"}, {dat, fc}, 32'h0);
        chk({nm, ".rst_flags"}, {27'h0, vld, fs, le, fe, fer}, 32'h0);
    endtask

    // cycle counter: "cycle c" is the interval following posedge c
    always @(posedge clk) cyc <= cyc + 1;

    // compare both instances against the model once per cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_fc.exists(cyc))  cur_fc  = exp_fc[cyc];
            if (exp_fer.exists(cyc)) cur_fer = exp_fer[cyc];
            cmp("hi", ifh.pix_vld, ifh.pix_data, ifh.frame_start, ifh.line_end,
                ifh.frame_end, ifh.frame_err, ifh.frame_cnt);
            cmp("lo", ifl.pix_vld, ifl.pix_data, ifl.frame_start, ifl.line_end,
                ifl.frame_end, ifl.frame_err, ifl.frame_cnt);
        end
    end

    // per-frame pixel tally and first pixel of each frame
    always @(negedge clk) begin
        if (ifh.pix_vld) begin
            mon_cnt++;
            if (ifh.frame_start) fs_pix = ifh.pix_data;
        end
    end

    // Drive one pin cycle and update the model. A pin value set after
    // posedge t is sampled at posedge t+1; its effect is visible in cycle t+2.
    task automatic step(input bit vs, input bit hr, input logic [7:0] d);
        int t;
        @(posedge clk);
        #1;
        vs_pin = vs;
        hr_pin = hr;
        d_pin  = d;
        t = cyc;
        if (vs && !pvs) begin
            if (m_act) begin
                exp_fe[t+2]  = 1'b1;
                exp_fer[t+2] = m_lerr || (m_lines != V) || hr;
                m_fc++;
                exp_fc[t+2]  = m_fc;
                m_act = cap;
            end else if (m_seen < FS) begin
                m_seen++;
            end else begin
                m_act = cap;
            end
            m_first = m_act;
            m_lines = 0;
            m_lerr  = 1'b0;
            if (hr) m_drop = 1'b1;
        end
        if (hr) begin
            if (m_nb % 2 == 1) begin
                if (m_act && !m_drop) begin
                    exp_pix[t+2] = px(m_hi, d);
                    if (m_first) exp_fs[t+2] = 1'b1;
                    m_first = 1'b0;
                end
            end else begin
                m_hi = d;
            end
            m_nb++;
        end else if (phr) begin
            if (m_act && !m_drop) begin
                exp_le[t+2] = 1'b1;
                m_lines++;
                if (m_nb != 2 * H) m_lerr = 1'b1;
            end
            m_nb   = 0;
            m_drop = 1'b0;
        end
        pvs = vs;
        phr = hr;
    endtask

    task automatic gap(input int n);
        repeat (n) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic line(input int np, input bit extra, input bit tag);
        logic [7:0] b;
        for (int i = 0; i < 2 * np + int'(extra); i++) begin
            b = 8'($urandom);
            if (tag && i == 0) b = 8'hF8;
            if (tag && i == 1) b = 8'h1F;
            step(1'b0, 1'b1, b);
        end
        gap(4);
    endtask

    task automatic frame(input int np0, input bit extra0);
        line(np0, extra0, 1'b1);
        line(H, 1'b0, 1'b0);
    endtask

    task automatic vedge(output int n);
        n = mon_cnt;
        mon_cnt = 0;
        repeat (3) step(1'b1, 1'b0, 8'h00);
        gap(3);
    endtask

    task automatic model_reset();
        exp_pix.delete(); exp_fs.delete(); exp_le.delete();
        exp_fe.delete();  exp_fer.delete(); exp_fc.delete();
        cur_fc = 8'h00; cur_fer = 1'b0; m_fc = 8'h00;
        m_act = 1'b0; m_seen = 0; m_first = 1'b0; m_lines = 0; m_lerr = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #2;
        zcheck("hi", ifh.pix_vld, ifh.pix_data, ifh.frame_start, ifh.line_end,
               ifh.frame_end, ifh.frame_err, ifh.frame_cnt);
        zcheck("lo", ifl.pix_vld, ifl.pix_data, ifl.frame_start, ifl.line_end,
               ifl.frame_end, ifl.frame_err, ifl.frame_cnt);
        rst_n = 1'b1;
        chk("px_model_F81F", 32'(px(8'hF8, 8'h1F)), 32'(EXP_F81F));
        gap(4);

        // skip two frames, then capture
        vedge(n);
        frame(H, 0); vedge(n); chk("skip_frame1_pix", n, 0);
        frame(H, 0); vedge(n); chk("skip_frame2_pix", n, 0);
        frame(H, 0); vedge(n); chk("frame3_pix", n, 8);
        chk("frame_cnt_after_f3", 32'(ifh.frame_cnt), 32'd1);
        frame(H, 0); vedge(n); chk("frame4_pix", n, 8);

        // short line, then clean frame
        frame(3, 0); vedge(n); chk("short_frame_pix", n, 7);
        chk("short_frame_err", 32'(ifh.frame_err), 32'd1);
        frame(H, 0); vedge(n);
        chk("clean_frame_err", 32'(ifh.frame_err), 32'd0);
        chk("pair_F8_1F", 32'(fs_pix), 32'(EXP_F81F));

        // disarm mid-frame, idle frame, re-arm
        line(H, 0, 1); cap = 1'b0; line(H, 0, 0);
        vedge(n); chk("disarm_frame_pix", n, 8);
        frame(H, 0); cap = 1'b1; vedge(n); chk("idle_frame_pix", n, 0);
        frame(H, 0); vedge(n); chk("rearm_frame_pix", n, 8);

        // odd byte count in a line
        frame(H, 1); vedge(n); chk("odd_frame_pix", n, 8);
        chk("odd_frame_err", 32'(ifh.frame_err), 32'd1);

        // vsync while href high
        line(H, 0, 1);
        repeat (4) step(1'b0, 1'b1, 8'($urandom));
        repeat (3) step(1'b1, 1'b1, 8'($urandom));
        repeat (3) step(1'b0, 1'b1, 8'($urandom));
        gap(4);
        chk("glitch_frame_err", 32'(ifh.frame_err), 32'd1);
        line(H, 0, 1); line(H, 0, 0); vedge(n);
        chk("post_glitch_err", 32'(ifh.frame_err), 32'd0);

        // reset in the middle of a captured line
        repeat (5) step(1'b0, 1'b1, 8'($urandom));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        zcheck("hi", ifh.pix_vld, ifh.pix_data, ifh.frame_start, ifh.line_end,
               ifh.frame_end, ifh.frame_err, ifh.frame_cnt);
        zcheck("lo", ifl.pix_vld, ifl.pix_data, ifl.frame_start, ifl.line_end,
               ifl.frame_end, ifl.frame_err, ifl.frame_cnt);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) step(1'b0, 1'b1, 8'($urandom));
        gap(4);
        vedge(n);
        frame(H, 0); vedge(n); chk("rst_skip1_pix", n, 0);
        frame(H, 0); vedge(n); chk("rst_skip2_pix", n, 0);
        frame(H, 0); vedge(n); chk("rst_capture_pix", n, 8);
        chk("rst_frame_cnt", 32'(ifh.frame_cnt), 32'd1);
        gap(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
